frame_wr_packer: RTL and testbench

- Upstream feeder of the DDR controller's memory-request port in the dashcam datapath.
- Accepts a 32-bit camera pixel-word stream and packs four words into one 128-bit beat.
- Tags each beat with a frame-relative DDR address, buffers beats in a small FIFO and issues single-beat write requests (mem_req/mem_we/mem_ack) to the controller.
- Reports frame completion and overflow to the capture sequencer.

---
 rtl/frame_wr_pkg.sv | 19 +
 rtl/frame_wr_fifo.sv | 61 ++++++
 rtl/frame_wr_packer.sv | 165 ++++++++++++++++
 tb/tb_frame_wr_packer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_wr_pkg.sv
// rtl/frame_wr_pkg.sv - shared types and constants for the frame write packer
package frame_wr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } wr_state_t;

    localparam int LANES          = 4;
    localparam int DEF_ADDR_WIDTH = 28;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int ENTRY_WIDTH    = DEF_ADDR_WIDTH + DEF_DATA_WIDTH;

    function automatic int entry_width(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/frame_wr_fifo.sv
// rtl/frame_wr_fifo.sv - synchronous {addr,data} beat FIFO with first-word-fall-through head
module frame_wr_fifo
    import frame_wr_pkg::*;
#(
    parameter int WIDTH = ENTRY_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_wr_packer.sv
// rtl/frame_wr_packer.sv - packs 32-bit pixel words into 128-bit DDR write beats; FRAME_WR_PINGPONG_EN adds ping-pong frame buffers
module frame_wr_packer
    import frame_wr_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 28,
    parameter int                    DATA_WIDTH  = 128,
    parameter int                    PIX_WIDTH   = 32,
    parameter int                    FIFO_DEPTH  = 8,
    parameter int                    FRAME_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR0  = 28'h0000000,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR1  = 28'h0100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIX_WIDTH-1:0]          pix_data,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic                          pix_sof,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          mem_we,
    output logic                          mem_req,
    input  logic                          mem_ack,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FRAME_WR_PINGPONG_EN
    ,
    output logic                          wr_buf_sel
`endif
);

    localparam int EW   = entry_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int IDXW = $clog2(FRAME_WORDS);
    localparam logic [IDXW-1:0]                  LAST_IDX = IDXW'(FRAME_WORDS - 1);
    localparam logic [1:0][ADDR_WIDTH-1:0]       BASES    = {BASE_ADDR1, BASE_ADDR0};
    localparam logic [ADDR_WIDTH-1:0]            LAST0    = BASE_ADDR0 + ADDR_WIDTH'(FRAME_WORDS - 1);

    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                accept;
    logic                                push;
    logic                                pop;
    logic [EW-1:0]                       push_data;
    logic [EW-1:0]                       head;
    logic [1:0]                          pack_cnt;
    logic [(LANES-1)*PIX_WIDTH-1:0]      lanes;
    logic [IDXW-1:0]                     beat_idx;
    logic                                base_sel;
    logic [ADDR_WIDTH-1:0]               cur_base;
    wr_state_t                           state;

    assign pix_ready = !fifo_full && !reset;
    assign accept    = pix_valid && pix_ready;
    // A sof word always lands in lane 0, so it can never complete a beat.
    assign push      = accept && !pix_sof && (pack_cnt == 2'(LANES - 1));
    assign cur_base  = BASES[base_sel];
    assign push_data = {cur_base + ADDR_WIDTH'(beat_idx), pix_data, lanes};
    assign pop       = (state == REQ) && mem_ack;

    frame_wr_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef FRAME_WR_PINGPONG_EN
    logic sof_seen;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_sel <= 1'b0;
            sof_seen <= 1'b0;
        end else if (accept && pix_sof) begin
            // The very first frame stays on buffer 0; later frames alternate.
            base_sel <= sof_seen ? !base_sel : base_sel;
            sof_seen <= 1'b1;
        end
    end
`else
    assign base_sel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pack_cnt <= '0;
            lanes    <= '0;
            beat_idx <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            if (pix_sof) begin
                if (pack_cnt != 2'd0) begin
                    overflow <= 1'b1;
                end
                lanes[PIX_WIDTH-1:0] <= pix_data;
                pack_cnt             <= 2'd1;
                beat_idx             <= '0;
            end else if (push) begin
                pack_cnt <= 2'd0;
                beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + IDXW'(1);
            end else begin
                lanes[pack_cnt*PIX_WIDTH +: PIX_WIDTH] <= pix_data;
                pack_cnt                               <= pack_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
`ifdef FRAME_WR_PINGPONG_EN
            wr_buf_sel <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        mem_addr  <= head[EW-1 -: ADDR_WIDTH];
                        mem_wdata <= head[DATA_WIDTH-1:0];
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= GAP;
                        // The stored address alone identifies the last beat of a frame.
`ifdef FRAME_WR_PINGPONG_EN
                        if (mem_addr == LAST0 ||
                            mem_addr == BASE_ADDR1 + ADDR_WIDTH'(FRAME_WORDS - 1)) begin
                            frame_done <= 1'b1;
                            wr_buf_sel <= (mem_addr != LAST0);
                        end
`else
                        if (mem_addr == LAST0) begin
                            frame_done <= 1'b1;
                        end
`endif
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_wr_packer.sv
// tb/tb_frame_wr_packer.sv - scoreboard bench for frame_wr_packer; build with FRAME_WR_PINGPONG_EN for the ping-pong run
module tb_frame_wr_packer;

`ifdef FRAME_WR_PINGPONG_EN
    localparam bit PP  = 1'b1;
    localparam int FW1 = 2;
`else
    localparam bit PP  = 1'b0;
    localparam int FW1 = 4;
`endif
    localparam int          FW0 = 4096;
    localparam logic [27:0] B0  = 28'h0000000;
    localparam logic [27:0] B1  = 28'h0100000;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pix_data   [2];
    logic         pix_valid  [2];
    logic         pix_sof    [2];
    logic         pix_ready  [2];
    logic [27:0]  mem_addr   [2];
    logic [127:0] mem_wdata  [2];
    logic         mem_we     [2];
    logic         mem_req    [2];
    logic         mem_ack    [2];
    logic         frame_done [2];
    logic         overflow   [2];
    logic [3:0]   fifo_level [2];
`ifdef FRAME_WR_PINGPONG_EN
    logic         wr_buf_sel [2];
    logic         sel_log    [2][4];
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [155:0] q0[$];
    logic [155:0] q1[$];

    bit           hold     [2];
    int           m_cnt    [2];
    logic [127:0] m_lanes  [2];
    int           m_idx    [2];
    bit           m_sel    [2];
    bit           m_seen   [2];
    int           ack_cnt  [2];
    int           last_rise[2];
    int           fd_cnt   [2];
    logic         req_prev [2];

    always #5 clk = ~clk;

    frame_wr_packer #(.FRAME_WORDS(FW0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .pix_data   (pix_data[0]),
        .pix_valid  (pix_valid[0]),
        .pix_ready  (pix_ready[0]),
        .pix_sof    (pix_sof[0]),
        .mem_addr   (mem_addr[0]),
        .mem_wdata  (mem_wdata[0]),
        .mem_we     (mem_we[0]),
        .mem_req    (mem_req[0]),
        .mem_ack    (mem_ack[0]),
        .frame_done (frame_done[0]),
        .overflow   (overflow[0]),
        .fifo_level (fifo_level[0])
`ifdef FRAME_WR_PINGPONG_EN
        ,
        .wr_buf_sel (wr_buf_sel[0])
`endif
    );

    frame_wr_packer #(.FRAME_WORDS(FW1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .pix_data   (pix_data[1]),
        .pix_valid  (pix_valid[1]),
        .pix_ready  (pix_ready[1]),
        .pix_sof    (pix_sof[1]),
        .mem_addr   (mem_addr[1]),
        .mem_wdata  (mem_wdata[1]),
        .mem_we     (mem_we[1]),
        .mem_req    (mem_req[1]),
        .mem_ack    (mem_ack[1]),
        .frame_done (frame_done[1]),
        .overflow   (overflow[1]),
        .fifo_level (fifo_level[1])
`ifdef FRAME_WR_PINGPONG_EN
        ,
        .wr_buf_sel (wr_buf_sel[1])
`endif
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int fw(input int d);
        return (d == 0) ? FW0 : FW1;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [155:0] qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int d, input logic [155:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic qpop(input int d, output logic [155:0] v);
        if (d == 0) v = q0.pop_front();
        else        v = q1.pop_front();
    endtask

    // Per-cycle monitor: acks requests, pops the scoreboard and checks spacing / frame_done.
    task automatic mon(input int d);
        logic [155:0] e;
        if (mem_req[d] === 1'b1 && req_prev[d] !== 1'b1) begin
            if (last_rise[d] >= 0)
                check("req_spacing", 160'(cyc - last_rise[d] >= 3), 160'(1));
            last_rise[d] = cyc;
        end
        req_prev[d] = mem_req[d];
        if (frame_done[d] === 1'b1) begin
            check("done_after_last_ack", 160'(ack_cnt[d] > 0 && (ack_cnt[d] % fw(d)) == 0), 160'(1));
`ifdef FRAME_WR_PINGPONG_EN
            if (fd_cnt[d] < 4) sel_log[d][fd_cnt[d]] = wr_buf_sel[d];
`endif
            fd_cnt[d]++;
        end
        if (mem_req[d] === 1'b1 && !hold[d]) begin
            if (mem_ack[d] !== 1'b1) begin
                if (qsize(d) == 0) begin
                    check("unexpected_req", 160'(1), 160'(0));
                end else begin
                    qpop(d, e);
                    check("wr_addr", 160'(mem_addr[d]), 160'(e[155:128]));
                    check("wr_data", 160'(mem_wdata[d]), 160'(e[127:0]));
                    check("wr_we", 160'(mem_we[d]), 160'(1));
                end
                ack_cnt[d]++;
                mem_ack[d] = 1'b1;
            end
        end else begin
            if (mem_req[d] === 1'b1 && qsize(d) > 0) begin
                e = qfront(d);
                check("held_addr_stable", 160'(mem_addr[d]), 160'(e[155:128]));
                check("held_data_stable", 160'(mem_wdata[d]), 160'(e[127:0]));
            end
            mem_ack[d] = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mon(0);
        mon(1);
    endtask

    task automatic model_word(input int d, input logic [31:0] w, input bit sof);
        if (sof) begin
            m_cnt[d] = 0;
            m_idx[d] = 0;
            if (PP) begin
                if (m_seen[d]) m_sel[d] = !m_sel[d];
                m_seen[d] = 1'b1;
            end
        end
        m_lanes[d][m_cnt[d]*32 +: 32] = w;
        if (m_cnt[d] == 3) begin
            qpush(d, {(m_sel[d] ? B1 : B0) + 28'(m_idx[d]), m_lanes[d]});
            m_idx[d] = (m_idx[d] == fw(d) - 1) ? 0 : m_idx[d] + 1;
            m_cnt[d] = 0;
        end else begin
            m_cnt[d]++;
        end
    endtask

    task automatic send_word(input int d, input logic [31:0] w, input bit sof);
        int n = 0;
        pix_data[d]  = w;
        pix_sof[d]   = sof;
        pix_valid[d] = 1'b1;
        while (pix_ready[d] !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("ready_timeout", 160'(0), 160'(1));
        model_word(d, w, sof);
        tick();
        pix_valid[d] = 1'b0;
        pix_sof[d]   = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        while ((qsize(d) != 0 || mem_req[d] !== 1'b0 || fifo_level[d] !== 4'd0) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check("drain_timeout", 160'(0), 160'(1));
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            pix_valid[d] = 1'b0;
            pix_sof[d]   = 1'b0;
            pix_data[d]  = '0;
            m_cnt[d]     = 0;
            m_lanes[d]   = '0;
            m_idx[d]     = 0;
            m_sel[d]     = 1'b0;
            m_seen[d]    = 1'b0;
            ack_cnt[d]   = 0;
            last_rise[d] = -1;
            fd_cnt[d]    = 0;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_pix_ready", 160'(pix_ready[d]), 160'(0));
            check("rst_mem_req", 160'(mem_req[d]), 160'(0));
            check("rst_mem_we", 160'(mem_we[d]), 160'(0));
            check("rst_mem_addr", 160'(mem_addr[d]), 160'(0));
            check("rst_mem_wdata", 160'(mem_wdata[d]), 160'(0));
            check("rst_frame_done", 160'(frame_done[d]), 160'(0));
            check("rst_overflow", 160'(overflow[d]), 160'(0));
            check("rst_fifo_level", 160'(fifo_level[d]), 160'(0));
        end
        reset = 1'b0;
        tick();
        for (int d = 0; d < 2; d++)
            check("post_rst_pix_ready", 160'(pix_ready[d]), 160'(1));
    endtask

    initial begin
        int reqs;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            hold[d]      = 1'b0;
            pix_valid[d] = 1'b0;
            pix_sof[d]   = 1'b0;
            pix_data[d]  = '0;
        end

        // Single beat with latency check
        do_reset();
        send_word(0, 32'h13572468, 1'b1);
        send_word(0, 32'h89ABCDEF, 1'b0);
        send_word(0, 32'h01234567, 1'b0);
        send_word(0, 32'hDEADBEEF, 1'b0);
        check("latency_req_low_n1", 160'(mem_req[0]), 160'(0));
        tick();
        check("latency_req_high_n2", 160'(mem_req[0]), 160'(1));
        wait_drain(0);
        check("single_acks", 160'(ack_cnt[0]), 160'(1));

        // Backpressure: fill the FIFO while acks are withheld
        do_reset();
        hold[0] = 1'b1;
        for (int i = 0; i < 32; i++)
            send_word(0, (32'(i) * 32'h01010101) ^ 32'hC3C30000, 1'b0);
        check("full_pix_ready", 160'(pix_ready[0]), 160'(0));
        check("full_fifo_level", 160'(fifo_level[0]), 160'(8));
        repeat (10) tick();
        check("full_level_held", 160'(fifo_level[0]), 160'(8));
        hold[0] = 1'b0;
        for (int i = 32; i < 40; i++)
            send_word(0, (32'(i) * 32'h01010101) ^ 32'hC3C30000, 1'b0);
        wait_drain(0);
        check("backpressure_acks", 160'(ack_cnt[0]), 160'(10));

        // Overflow on sof with a partial beat
        do_reset();
        send_word(0, 32'h11111111, 1'b0);
        send_word(0, 32'h22222222, 1'b0);
        check("no_overflow_yet", 160'(overflow[0]), 160'(0));
        send_word(0, 32'h5050A0A0, 1'b1);
        check("overflow_set", 160'(overflow[0]), 160'(1));
        send_word(0, 32'h33333333, 1'b0);
        send_word(0, 32'h44444444, 1'b0);
        send_word(0, 32'h55555555, 1'b0);
        wait_drain(0);
        check("overflow_sticky", 160'(overflow[0]), 160'(1));
        check("overflow_acks", 160'(ack_cnt[0]), 160'(1));

        // Reset while a request is pending with beats queued
        do_reset();
        hold[0] = 1'b1;
        for (int i = 0; i < 12; i++)
            send_word(0, 32'hA0000000 + 32'(i), 1'b0);
        check("pre_rst_req", 160'(mem_req[0]), 160'(1));
        check("pre_rst_level", 160'(fifo_level[0]), 160'(3));
        do_reset();
        hold[0] = 1'b0;
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req[0] === 1'b1) reqs++;
        end
        check("no_reissue_after_reset", 160'(reqs), 160'(0));

        // Frame boundary behaviour on the short-frame instance
        do_reset();
        if (PP) begin
            for (int f = 0; f < 2; f++)
                for (int i = 0; i < 8; i++)
                    send_word(1, 32'hF0000000 + 32'(f * 16 + i), i == 0);
            wait_drain(1);
            check("pp_frame_done_count", 160'(fd_cnt[1]), 160'(2));
            check("pp_acks", 160'(ack_cnt[1]), 160'(4));
`ifdef FRAME_WR_PINGPONG_EN
            check("pp_buf_sel_0", 160'(sel_log[1][0]), 160'(0));
            check("pp_buf_sel_1", 160'(sel_log[1][1]), 160'(1));
`endif
        end else begin
            for (int i = 0; i < 16; i++)
                send_word(1, 32'hE0000000 + 32'(i * 3), i == 0);
            wait_drain(1);
            check("frame_done_count", 160'(fd_cnt[1]), 160'(1));
            check("frame_acks", 160'(ack_cnt[1]), 160'(4));
        end
        check("main_no_frame_done", 160'(fd_cnt[0]), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
